// File: rtl/riscv_mmio_pkg.sv
// Shared address map and UART state encoding for the core's MMIO peripherals.
package riscv_mmio_pkg;

  localparam logic [31:0] UART_BASE  = 32'h0000_1000;
  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock byte queue. The head entry is always visible on rdata.
// A push into a full queue is accepted only when a pop happens on the same
// edge. Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  // Pointer and occupancy bookkeeping; reset discards all queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's data-memory bus.
// TXDATA (+0) queues a byte, STATUS (+4) reports {overflow, full, busy}
// and any write to it clears the sticky overflow flag.
// tx is registered from the FSM state, so the line trails the state by one
// cycle: a push at edge N gives the start bit at edge N+2.
module mmio_uart_tx
  import riscv_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = UART_BASE,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        mmio_sel,
  output logic [31:0] mmio_rdata,
  output logic        tx,
  output logic        busy,
  output uart_state_e dbg_state
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e    state_q;
  logic [CW-1:0]  clk_cnt_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shreg_q;
  logic           tx_q;
  logic           busy_q;
  logic           busy_d;
  logic           overflow_q;
  logic           overflow_d;

  logic           wr_txdata;
  logic           wr_status;
  logic           rd_status;
  logic           bit_end;
  logic           pop;
  logic           going_idle;
  logic           push_ok;
  logic [FCW-1:0] cnt_after;

  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_head;
  logic [FCW-1:0] fifo_count;

  logic           unused_bits;
  assign unused_bits = ^{WriteData[31:8], ALUResult[1:0]};

  // Address decode: one 8-byte window, bit 2 picks the register.
  assign mmio_sel  = (ALUResult[31:3] == BASE_ADDR[31:3]);
  assign wr_txdata = MemWrite & mmio_sel & (ALUResult[2] == TXDATA_OFS[2]);
  assign wr_status = MemWrite & mmio_sel & (ALUResult[2] == STATUS_OFS[2]);
  assign rd_status = mmio_sel & (ALUResult[2] == STATUS_OFS[2]);
  assign bit_end   = (clk_cnt_q == CNT_LAST);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (wr_txdata),
    .pop   (pop),
    .wdata (WriteData[7:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Pop decision and next-cycle busy/overflow, derived from current state.
  always_comb begin
    pop        = 1'b0;
    going_idle = 1'b0;
    case (state_q)
      IDLE: begin
        pop        = ~fifo_empty;
        going_idle = fifo_empty;
      end
      STOP: begin
        if (bit_end) begin
          pop        = ~fifo_empty;
          going_idle = fifo_empty;
        end
      end
      default: begin
        pop        = 1'b0;
        going_idle = 1'b0;
      end
    endcase

    push_ok   = wr_txdata & (~fifo_full | pop);
    cnt_after = fifo_count + FCW'(push_ok) - FCW'(pop);
    busy_d    = ~going_idle | (cnt_after != '0);

    overflow_d = overflow_q;
    if (wr_txdata && !push_ok) begin
      overflow_d = 1'b1;
    end else if (wr_status) begin
      overflow_d = 1'b0;
    end
  end

  // Transmit FSM with baud/bit counters, shift register and registered tx.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shreg_q[0];
        default: tx_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
          if (!fifo_empty) begin
            shreg_q <= fifo_head;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            shreg_q   <= {1'b0, shreg_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              state_q   <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (!fifo_empty) begin
              shreg_q <= fifo_head;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered busy and sticky overflow flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Combinational read path; TXDATA and unselected addresses read zero.
  always_comb begin
    mmio_rdata = 32'h0;
    if (rd_status) begin
      mmio_rdata = {29'b0, overflow_q, fifo_full, busy_q};
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores push expected bytes, a tx-line
// monitor decodes frames and compares them against the expected queue.
module tb_mmio_uart_tx;
  import riscv_mmio_pkg::*;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        mmio_sel;
  logic [31:0] mmio_rdata;
  logic        tx;
  logic        busy;
  uart_state_e dbg_state;

  mmio_uart_tx #(
    .BASE_ADDR    (32'h0000_1000),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MemWrite   (MemWrite),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .mmio_sel   (mmio_sel),
    .mmio_rdata (mmio_rdata),
    .tx         (tx),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         start_log[$];
  int         checks = 0;
  int         errors = 0;
  int         frames_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @cyc %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; the store lands on the next posedge.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    ALUResult = addr;
    WriteData = data;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
    ALUResult = 32'h0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    ALUResult = addr;
    #1;
    chk(name, mmio_rdata, exp);
    ALUResult = 32'h0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("frame_timeout", 32'(frames_done >= target), 32'd1);
  endtask

  // ---------------- monitor: decode tx frames ----------------
  initial begin
    bit         mon_active;
    int         mon_cnt;
    logic [7:0] mon_byte;
    logic [7:0] e;
    mon_active = 1'b0;
    mon_cnt    = 0;
    mon_byte   = 8'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          mon_byte   = 8'h0;
          start_log.push_back(cyc);
        end
      end else begin
        mon_cnt++;
        if (mon_cnt == 1) begin
          chk("start_bit", 32'(tx), 32'd0);
        end else if (mon_cnt >= 5 && mon_cnt <= 33 && ((mon_cnt - 1) % CPB) == 0) begin
          mon_byte[(mon_cnt - 5) / CPB] = tx;
        end else if (mon_cnt == 37) begin
          chk("stop_bit", 32'(tx), 32'd1);
          mon_active = 1'b0;
          frames_done++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=%h expected=none", mon_byte);
          end else begin
            e = exp_q.pop_front();
            chk("frame_byte", 32'(mon_byte), 32'(e));
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    int f;
    int s0;
    rst       = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = 32'h0;
    WriteData = 32'h0;

    // 1: reset state
    #20;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    read_chk("rst_status", 32'h1004, 32'h0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // 2: single byte 0xA5, latency and busy
    s0 = start_log.size();
    exp_q.push_back(8'hA5);
    store(32'h1000, 32'h0000_00A5);
    n = cyc;
    wait_to(n + 20);
    chk("a5_busy_mid", 32'(busy), 32'd1);
    read_chk("a5_status_mid", 32'h1004, 32'h1);
    wait_frames(1, 200);
    chk("a5_latency", 32'(start_log[s0]), 32'(n + 2));
    wait_to(n + 43);
    chk("a5_busy_after", 32'(busy), 32'd0);
    chk("a5_tx_idle", 32'(tx), 32'd1);

    // 3: back-to-back frames with no idle gap
    s0 = start_log.size();
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    store(32'h1000, 32'h41);
    n = cyc;
    store(32'h1000, 32'h42);
    for (int k = 0; k < 20; k++) begin
      wait_to(n + 1 + 4 * k);
      read_chk("b2b_status_busy", 32'h1004, 32'h1);
    end
    wait_frames(3, 300);
    chk("b2b_first_start", 32'(start_log[s0]), 32'(n + 2));
    chk("b2b_gap", 32'(start_log[s0 + 1] - start_log[s0]), 32'(10 * CPB));
    wait_to(n + 84);
    chk("b2b_busy_after", 32'(busy), 32'd0);

    // 4: overflow with six consecutive stores
    for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
    for (int b = 1; b <= 6; b++) store(32'h1000, 32'(b));
    read_chk("ovf_status_full", 32'h1004, 32'h7);
    store(32'h1004, 32'hDEAD_BEEF);
    read_chk("ovf_cleared", 32'h1004, 32'h3);
    read_chk("txdata_reads_zero", 32'h1000, 32'h0);
    wait_frames(8, 400);
    wait_to(cyc + 50);
    chk("ovf_no_extra_frames", 32'(frames_done), 32'd8);
    read_chk("ovf_status_idle", 32'h1004, 32'h0);

    // 5: reset mid-DATA of a 0xFF frame with a second byte queued
    store(32'h1000, 32'hFF);
    n = cyc;
    store(32'h1000, 32'h11);
    wait_to(n + 20);
    chk("abort_state_data", 32'(dbg_state == DATA), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    read_chk("abort_status", 32'h1004, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    f = frames_done;
    wait_to(cyc + 60);
    chk("abort_no_residual", 32'(frames_done), 32'(f));
    chk("abort_idle_busy", 32'(busy), 32'd0);

    // 5b: reset during the start bit forces tx high asynchronously
    store(32'h1000, 32'h00);
    n = cyc;
    wait_to(n + 3);
    chk("startbit_low", 32'(tx), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("startbit_abort_tx", 32'(tx), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    // 6: unselected store and a TXDATA load
    f = frames_done;
    MemWrite  = 1'b1;
    ALUResult = 32'h2000;
    WriteData = 32'h55;
    #1;
    chk("unsel_sel", 32'(mmio_sel), 32'd0);
    chk("unsel_rdata", mmio_rdata, 32'h0);
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
    ALUResult = 32'h1000;
    #1;
    chk("load_sel", 32'(mmio_sel), 32'd1);
    chk("load_rdata", mmio_rdata, 32'h0);
    ALUResult = 32'h1008;
    #1;
    chk("next_window_sel", 32'(mmio_sel), 32'd0);
    ALUResult = 32'h0;
    wait_to(cyc + 60);
    chk("unsel_no_frame", 32'(frames_done), 32'(f));
    chk("unsel_busy", 32'(busy), 32'd0);
    read_chk("unsel_status", 32'h1004, 32'h0);

    // final report
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
